// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the outstanding-request LSU
// Contents: RV32I load/store funct3 codes, the tracking-queue entry type,
//           lsu_misaligned() and lsu_load_extract().
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Sideband meta is kept in a separate array because its width is a
  // parameter of the top module.
  typedef struct packed {
    logic        done;
    logic        fault;
    logic        is_store;
    logic        reg_wen;   // already qualified with rd!=0 and no fault
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [1:0]  off;       // addr[1:0], selects the load byte lane
    logic [31:0] result;
  } lsu_entry_t;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lsu_load_extract(input logic [31:0] rdata,
                                                   input logic [2:0]  funct3,
                                                   input logic [1:0]  off);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (funct3)
      LB:      return {{24{sh[7]}}, sh[7:0]};
      LH:      return {{16{sh[15]}}, sh[15:0]};
      LBU:     return {24'h0, sh[7:0]};
      LHU:     return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// rtl/lsu_store_align.sv - store byte-lane mask and data alignment
// Ports: size_i (funct3[1:0]), off_i (addr[1:0]), rs2_i (store data)
//        -> wmask_o (byte lanes), wdata_o (lane-shifted data).
module lsu_store_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    wmask_o = 4'h0;
    wdata_o = rs2_i << {off_i, 3'b000};
    case (size_i)
      SB[1:0]: wmask_o = 4'b0001 << off_i;
      SH[1:0]: wmask_o = 4'b0011 << off_i;
      SW[1:0]: begin
        wmask_o = 4'hF;
        wdata_o = rs2_i;
      end
      default: wmask_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/lsu_outstanding.sv
// rtl/lsu_outstanding.sv - in-order LSU with up to DEPTH outstanding memory ops
// Ports: clk/rst; in_* upstream op (valid/ready); out_* in-order retirement
//        (valid/ready); mem_req_* request channel (valid/ready); mem_rsp_*
//        in-order responses (valid only); flush discards every queued op.
module lsu_outstanding
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int META_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic              in_reg_wen,
  input  logic              in_mem_ren,
  input  logic              in_mem_wen,
  input  logic [META_W-1:0] in_meta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [4:0]        out_rd,
  output logic              out_reg_wen,
  output logic [META_W-1:0] out_meta,
  output logic              out_fault,
  output logic              out_fault_store,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              flush
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);

  lsu_entry_t        ent_q  [DEPTH];
  logic [META_W-1:0] meta_q [DEPTH];

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW:0]   head_q, head_d, tail_q, tail_d;
  // inflight counts every issued request not yet answered, including the
  // ones that will be dropped by draining.
  logic [IW-1:0] drain_q, drain_d, inflight_q, inflight_d;

  logic [PW:0] count;
  logic        full, empty;
  assign count = tail_q - head_q;
  assign full  = (count == (PW + 1)'(DEPTH));
  assign empty = (count == '0);

  logic is_mem, mis, aligned_mem, room, accept, issue, pop, rsp_cnt;
  assign is_mem      = in_mem_ren | in_mem_wen;
  assign mis         = is_mem & lsu_misaligned(in_funct3[1:0], in_addr[1:0]);
  assign aligned_mem = is_mem & !mis;
  assign room        = inflight_q < DEPTH_C;

  assign in_ready      = !full & !flush & (!aligned_mem | (mem_req_ready & room));
  assign accept        = in_valid & in_ready;
  assign mem_req_valid = in_valid & aligned_mem & !full & !flush & room;
  assign issue         = mem_req_valid & mem_req_ready;

  assign mem_req_wen  = in_mem_wen;
  assign mem_req_addr = {in_addr[XLEN-1:2], 2'b00};

  lsu_store_align u_store_align (
    .size_i  (in_funct3[1:0]),
    .off_i   (in_addr[1:0]),
    .rs2_i   (in_wdata),
    .wmask_o (mem_req_wmask),
    .wdata_o (mem_req_wdata)
  );

  // Response pointer: oldest queued entry still waiting for memory.
  logic          pend_found;
  logic [PW-1:0] pend_idx;
  always_comb begin
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!pend_found && ((PW + 1)'(i) < count) &&
          !ent_q[head_q[PW-1:0] + PW'(i)].done) begin
        pend_found = 1'b1;
        pend_idx   = head_q[PW-1:0] + PW'(i);
      end
    end
  end

  logic cap;
  assign cap     = mem_rsp_valid & !flush & (drain_q == '0) & pend_found;
  assign rsp_cnt = mem_rsp_valid & (inflight_q != '0);

  logic [PW-1:0] hidx;
  assign hidx            = head_q[PW-1:0];
  assign out_valid       = !empty & ent_q[hidx].done;
  assign pop             = out_valid & out_ready & !flush;
  assign out_result      = ent_q[hidx].result;
  assign out_rd          = ent_q[hidx].rd;
  assign out_meta        = meta_q[hidx];
  assign out_reg_wen     = out_valid & ent_q[hidx].reg_wen;
  assign out_fault       = out_valid & ent_q[hidx].fault;
  assign out_fault_store = out_valid & ent_q[hidx].fault & ent_q[hidx].is_store;

  lsu_entry_t new_ent;
  always_comb begin
    new_ent          = '0;
    new_ent.done     = !aligned_mem;
    new_ent.fault    = mis;
    new_ent.is_store = in_mem_wen;
    new_ent.reg_wen  = in_reg_wen & (in_rd != 5'd0) & !mis;
    new_ent.rd       = in_rd;
    new_ent.funct3   = in_funct3;
    new_ent.off      = in_addr[1:0];
    new_ent.result   = in_addr;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    drain_d    = drain_q;
    inflight_d = inflight_q;
    if (flush) begin
      // A response landing in the flush cycle is one of the dropped ones.
      head_d     = '0;
      tail_d     = '0;
      drain_d    = inflight_q - IW'(rsp_cnt);
      inflight_d = inflight_q - IW'(rsp_cnt);
    end else begin
      if (accept) tail_d = tail_q + 1'b1;
      if (pop)    head_d = head_q + 1'b1;
      if (mem_rsp_valid && drain_q != '0) drain_d = drain_q - 1'b1;
      inflight_d = inflight_q + IW'(issue) - IW'(rsp_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      drain_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]  <= '0;
        meta_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      drain_q    <= drain_d;
      inflight_q <= inflight_d;
      if (accept) begin
        ent_q[tail_q[PW-1:0]]  <= new_ent;
        meta_q[tail_q[PW-1:0]] <= in_meta;
      end
      if (cap) begin
        ent_q[pend_idx].done <= 1'b1;
        if (!ent_q[pend_idx].is_store) begin
          ent_q[pend_idx].result <= lsu_load_extract(mem_rsp_rdata, ent_q[pend_idx].funct3,
                                                     ent_q[pend_idx].off);
        end
      end
    end
  end

  // A response with nothing pending and nothing to drain is a protocol error.
  always_ff @(posedge clk) begin
    if (!rst && mem_rsp_valid && !flush) begin
      assert (drain_q != '0 || pend_found);
    end
  end

endmodule

// File: tb/tb_lsu_outstanding.sv
// tb/tb_lsu_outstanding.sv - scoreboard bench for lsu_outstanding
module tb_lsu_outstanding;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        in_reg_wen, in_mem_ren, in_mem_wen;
  logic [63:0] in_meta;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_reg_wen, out_fault, out_fault_store;
  logic [63:0] out_meta;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        flush;

  lsu_outstanding #(.XLEN(32), .DEPTH(4), .META_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_funct3(in_funct3), .in_reg_wen(in_reg_wen),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_meta(in_meta),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_wen(out_reg_wen), .out_meta(out_meta),
    .out_fault(out_fault), .out_fault_store(out_fault_store),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int retired = 0;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        fault;
    logic        fstore;
    logic [63:0] meta;
  } exp_t;
  exp_t sb[$];

  logic        req_v, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input logic rwen,
                          input logic fault, input logic fstore, input logic [63:0] meta);
    exp_t e;
    e.result = res; e.rd = rd; e.reg_wen = rwen; e.fault = fault; e.fstore = fstore; e.meta = meta;
    sb.push_back(e);
  endtask

  // Scoreboard: every retirement is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      retired++;
      if (sb.size() == 0) begin
        check("unexpected_retire", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ret_result", 64'(out_result), 64'(e.result));
        check("ret_flags", 64'({out_fault, out_fault_store, out_reg_wen, out_rd}),
              64'({e.fault, e.fstore, e.reg_wen, e.rd}));
        check("ret_meta", out_meta, e.meta);
      end
    end
  end

  // Drives one op at posedge+1, waits for acceptance, returns at the next posedge+1.
  task automatic issue(input logic [2:0] f3, input logic ren, input logic wen, input logic rwen,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [63:0] meta);
    in_valid = 1'b1; in_funct3 = f3; in_mem_ren = ren; in_mem_wen = wen; in_reg_wen = rwen;
    in_rd = rd; in_addr = addr; in_wdata = wd; in_meta = meta;
    #1;
    for (int k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    req_v = mem_req_valid; req_wen = mem_req_wen; req_addr = mem_req_addr;
    req_wdata = mem_req_wdata; req_wmask = mem_req_wmask;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = d;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int r0;

  initial begin
    rst = 1'b1; in_valid = 0; in_addr = 0; in_wdata = 0; in_rd = 0; in_funct3 = 0;
    in_reg_wen = 0; in_mem_ren = 0; in_mem_wen = 0; in_meta = 0; out_ready = 1'b1;
    mem_req_ready = 1'b1; mem_rsp_valid = 0; mem_rsp_rdata = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_flags", 64'({out_fault, out_fault_store, out_reg_wen, mem_req_valid}), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_rd_meta", 64'(out_rd) | out_meta, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // LW, response one cycle after accept, result two cycles after accept
    push_exp(32'hDEADBEEF, 5'd1, 1'b1, 1'b0, 1'b0, 64'hA1);
    issue(3'b010, 1, 0, 1, 5'd1, 32'h8000_0004, 32'h0, 64'hA1);
    check("lw_req", 64'({req_v, req_wen}), 64'b10);
    check("lw_req_addr", 64'(req_addr), 64'h8000_0004);
    check("lw_not_early", 64'(out_valid), 64'd0);
    respond(32'hDEADBEEF);
    check("lw_latency", 64'(out_valid), 64'd1);
    wait_drain();

    // LB / LBU lane 3 extraction
    push_exp(32'hFFFF_FF80, 5'd2, 1'b1, 1'b0, 1'b0, 64'hB2);
    issue(3'b000, 1, 0, 1, 5'd2, 32'h0000_1003, 32'h0, 64'hB2);
    check("lb_req_addr", 64'(req_addr), 64'h0000_1000);
    respond(32'h80FF_1234);
    push_exp(32'h0000_0080, 5'd3, 1'b1, 1'b0, 1'b0, 64'hB3);
    issue(3'b100, 1, 0, 1, 5'd3, 32'h0000_1003, 32'h0, 64'hB3);
    respond(32'h80FF_1234);
    wait_drain();

    // SH at offset 2, SB at offset 3
    push_exp(32'h0000_2002, 5'd0, 1'b0, 1'b0, 1'b0, 64'hC4);
    issue(3'b001, 0, 1, 0, 5'd0, 32'h0000_2002, 32'h0000_ABCD, 64'hC4);
    check("sh_req", 64'({req_v, req_wen, req_wmask}), 64'b11_1100);
    check("sh_wdata", 64'(req_wdata), 64'hABCD_0000);
    check("sh_addr", 64'(req_addr), 64'h0000_2000);
    respond(32'h0);
    push_exp(32'h0000_2007, 5'd0, 1'b0, 1'b0, 1'b0, 64'hC5);
    issue(3'b000, 0, 1, 0, 5'd0, 32'h0000_2007, 32'h0000_0055, 64'hC5);
    check("sb_req", 64'({req_v, req_wmask}), 64'b1_1000);
    check("sb_wdata", 64'(req_wdata), 64'h5500_0000);
    respond(32'h0);
    wait_drain();

    // misaligned LW and SW: no request, fault retires next cycle
    push_exp(32'h0000_3002, 5'd5, 1'b0, 1'b1, 1'b0, 64'hD6);
    issue(3'b010, 1, 0, 1, 5'd5, 32'h0000_3002, 32'h0, 64'hD6);
    check("mis_lw_no_req", 64'(req_v), 64'd0);
    check("mis_lw_next_cycle", 64'({out_valid, out_fault}), 64'b11);
    push_exp(32'h0000_4001, 5'd0, 1'b0, 1'b1, 1'b1, 64'hD7);
    issue(3'b010, 0, 1, 0, 5'd0, 32'h0000_4001, 32'h1, 64'hD7);
    check("mis_sw_no_req", 64'(req_v), 64'd0);
    wait_drain();

    // non-memory ops, rd=0 suppresses reg_wen
    push_exp(32'h1234_5678, 5'd7, 1'b1, 1'b0, 1'b0, 64'hE8);
    issue(3'b000, 0, 0, 1, 5'd7, 32'h1234_5678, 32'h0, 64'hE8);
    check("alu_next_cycle", 64'(out_valid), 64'd1);
    push_exp(32'h0BAD_F00D, 5'd0, 1'b0, 1'b0, 1'b0, 64'hE9);
    issue(3'b000, 0, 0, 1, 5'd0, 32'h0BAD_F00D, 32'h0, 64'hE9);
    wait_drain();

    // four loads back-to-back, fifth stalls, in-order retirement
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h1000_0000 + 32'(i), 5'(10 + i), 1'b1, 1'b0, 1'b0, 64'(16'hF00 + i));
      issue(3'b010, 1, 0, 1, 5'(10 + i), 32'h100 + 32'(4 * i), 32'h0, 64'(16'hF00 + i));
      check("b2b_req", 64'(req_v), 64'd1);
    end
    in_valid = 1'b1; in_mem_ren = 1'b1; in_mem_wen = 1'b0; in_funct3 = 3'b010; in_addr = 32'h200;
    #1;
    check("full_stall", 64'({in_ready, mem_req_valid}), 64'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) respond(32'h1000_0000 + 32'(i));
    check("hold_valid", 64'({out_valid, out_result}), {31'd0, 1'b1, 32'h1000_0000});
    @(posedge clk); #1;
    check("hold_stable", 64'({out_valid, out_result}), {31'd0, 1'b1, 32'h1000_0000});
    out_ready = 1'b1;
    wait_drain();

    // two loads, flush, new LW: first two responses dropped
    issue(3'b010, 1, 0, 1, 5'd20, 32'h300, 32'h0, 64'h1);
    issue(3'b010, 1, 0, 1, 5'd21, 32'h304, 32'h0, 64'h2);
    flush = 1'b1;
    #1;
    check("flush_blocks", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_empty", 64'(out_valid), 64'd0);
    r0 = retired;
    push_exp(32'hCCCC_0003, 5'd22, 1'b1, 1'b0, 1'b0, 64'h3);
    issue(3'b010, 1, 0, 1, 5'd22, 32'h308, 32'h0, 64'h3);
    respond(32'hAAAA_0001);
    respond(32'hBBBB_0002);
    respond(32'hCCCC_0003);
    repeat (3) @(posedge clk);
    #1;
    check("flush_one_pulse", 64'(retired - r0), 64'd1);
    wait_drain();

    // response in the flush cycle counts as dropped
    issue(3'b010, 1, 0, 1, 5'd23, 32'h400, 32'h0, 64'h4);
    flush = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hEEEE_EEEE;
    @(posedge clk); #1;
    flush = 1'b0; mem_rsp_valid = 1'b0;
    r0 = retired;
    push_exp(32'hD00D_0004, 5'd24, 1'b1, 1'b0, 1'b0, 64'h5);
    issue(3'b010, 1, 0, 1, 5'd24, 32'h404, 32'h0, 64'h5);
    respond(32'hD00D_0004);
    wait_drain();
    check("flush_rsp_one", 64'(retired - r0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
